data_memory_unit: RTL and testbench
===================================

DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of one memory word.
REQ-002 Parameter ADDR_WIDTH, default 32, width of the incoming byte-free word address.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL be a power of two.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mem_enable  input  1  access request this cycle (from decode stage).
REQ-007 store_enable  input  1  1 = store, 0 = load; qualified by mem_enable.
REQ-008 dmem_address  input  ADDR_WIDTH  word index of the access.
REQ-009 dmem_dataIn  input  DATA_WIDTH  store data.
REQ-010 dmem_dataOut  output  DATA_WIDTH  registered load data, consumed by the EXE/MEM stage.
REQ-011 busy  output  1  high while the post-reset clear sweep runs.
REQ-012 addr_err  output  1  sticky flag: some access had an out-of-range address.
REQ-013 load_count  output  16  number of accepted loads, wraps at 2^16.
REQ-014 store_count  output  16  number of accepted stores, wraps at 2^16.

Function
REQ-015 The FSM SHALL have two states: INIT (clear sweep) and READY; reset enters INIT.
REQ-016 In INIT, one word per cycle SHALL be written to zero, from index 0 to DEPTH-1; after writing DEPTH-1 the FSM SHALL go to READY on the next edge (DEPTH cycles in INIT).
REQ-017 busy SHALL be 1 exactly while in INIT.
REQ-018 In INIT all requests SHALL be ignored: no write, no counter change, dmem_dataOut held at 0, addr_err unchanged.
REQ-019 The access is in range when dmem_address < DEPTH.
REQ-020 A load (READY, mem_enable=1, store_enable=0) issued in cycle N SHALL present mem[dmem_address] on dmem_dataOut from the edge ending cycle N (visible in cycle N+1). This is a 1-cycle latency.
REQ-021 dmem_dataOut SHALL hold its last value until the next accepted load.
REQ-022 A store (READY, mem_enable=1, store_enable=1) SHALL write dmem_dataIn to mem[dmem_address] at the edge ending its cycle. A load in the next cycle to the same address SHALL return the new data.
REQ-023 store_enable with mem_enable=0 SHALL be ignored.
REQ-024 An out-of-range store SHALL NOT modify the array.
REQ-025 An out-of-range load SHALL return 0 on dmem_dataOut.
REQ-026 Any out-of-range access SHALL set addr_err=1, which stays set until reset.
REQ-027 An out-of-range access SHALL still increment the respective counter.
REQ-028 load_count and store_count SHALL each increment by 1 per accepted access and wrap from 0xFFFF to 0x0000.
REQ-029 The block has a single port: at most one access per cycle. No simultaneous read/write case exists.

Reset
REQ-030 While rst=1, regardless of clk, the outputs SHALL be: dmem_dataOut=0, busy=1, addr_err=0, load_count=0, store_count=0, FSM=INIT, sweep index=0.
REQ-031 Reset asserted mid-sweep or mid-access SHALL abort it. The sweep SHALL restart from index 0 after release.
REQ-032 Array contents are not reset asynchronously; they are zeroed only by the INIT sweep.

Structure
REQ-033 A shared package dmem_pkg SHALL hold the DATA_WIDTH, ADDR_WIDTH and DEPTH defaults, the counter width (16), and the FSM state encoding (INIT=0, READY=1).
REQ-034 The storage SHALL be a sub-module dmem_array: single-port, synchronous write, registered read, no reset. The FSM, range check, counters and error flag stay in data_memory_unit.

Verification
REQ-035 Bench SHALL cover the following directed scenarios:
- Reset release -> busy=1 for exactly 256 cycles, then 0; a load to address 5 returns 0.
- Store 0xDEADBEEF_CAFEF00D to address 10, then load address 10 next cycle -> dmem_dataOut=0xDEADBEEF_CAFEF00D one cycle after the load; store_count=1, load_count=1.
- Store to address 300 (DEPTH=256) -> addr_err=1, array unchanged; load address 300 -> dmem_dataOut=0; addr_err stays 1 through further valid accesses.
- store_enable=1 with mem_enable=0 at address 3 -> mem[3] and store_count unchanged. Requests issued during busy=1 -> ignored.
- Reset asserted at sweep index 100 -> outputs return to reset values at once; after release busy lasts a full 256 cycles.
- 65536 back-to-back loads -> load_count wraps to 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults and FSM encoding for the data memory unit
package dmem_pkg;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DEPTH = 256;
   localparam int CNT_WIDTH = 16;
   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage, synchronous write, registered read, no reset
module dmem_array #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]    wdata_i,
   output logic [DATA_WIDTH-1:0]    rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: data memory with post-reset clear sweep, range check, error flag and access counters
module data_memory_unit
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_enable,
   input  logic                  store_enable,
   input  logic [ADDR_WIDTH-1:0] dmem_address,
   input  logic [DATA_WIDTH-1:0] dmem_dataIn,
   output logic [DATA_WIDTH-1:0] dmem_dataOut,
   output logic                  busy,
   output logic                  addr_err,
   output logic [CNT_WIDTH-1:0]  load_count,
   output logic [CNT_WIDTH-1:0]  store_count
);
   localparam int IW = $clog2(DEPTH);
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d, addr;
   logic [CNT_WIDTH-1:0] load_q, store_q;
   logic err_q, zero_q, in_range, ld, st, we, re;
   logic [DATA_WIDTH-1:0] wdata, rdata;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= INIT;
      else state_q <= state_d;
   end
   always_comb state_d = (state_q == INIT && idx_q == IW'(DEPTH-1)) ? READY : state_q;
   always_comb begin
      busy = state_q == INIT;
      in_range = dmem_address < ADDR_WIDTH'(DEPTH);
      ld = !busy && mem_enable && !store_enable;
      st = !busy && mem_enable && store_enable;
      we = busy || (st && in_range);
      re = ld && in_range;
      addr = busy ? idx_q : dmem_address[IW-1:0];
      wdata = busy ? '0 : dmem_dataIn;
      idx_d = busy ? idx_q + IW'(1) : idx_q;
   end
   // zero_q masks the array's stale read register after reset and on out-of-range loads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         load_q <= '0;
         store_q <= '0;
         err_q <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         idx_q <= idx_d;
         if (ld) load_q <= load_q + CNT_WIDTH'(1);
         if (st) store_q <= store_q + CNT_WIDTH'(1);
         if ((ld || st) && !in_range) err_q <= 1'b1;
         if (ld) zero_q <= !in_range;
      end
   end
   dmem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
      .clk(clk),
      .we_i(we),
      .re_i(re),
      .addr_i(addr),
      .wdata_i(wdata),
      .rdata_o(rdata)
   );
   assign dmem_dataOut = zero_q ? '0 : rdata;
   assign addr_err = err_q;
   assign load_count = load_q;
   assign store_count = store_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed checks of sweep, load/store, range errors, reset abort and counter wrap
module tb_data_memory_unit;
   logic clk = 1'b0, rst = 1'b1, mem_enable = 1'b0, store_enable = 1'b0;
   logic [31:0] dmem_address = '0;
   logic [63:0] dmem_dataIn = '0, dmem_dataOut;
   logic busy, addr_err;
   logic [15:0] load_count, store_count;
   int cmp = 0, fails = 0;

   data_memory_unit dut (
      .clk(clk), .rst(rst), .mem_enable(mem_enable), .store_enable(store_enable),
      .dmem_address(dmem_address), .dmem_dataIn(dmem_dataIn), .dmem_dataOut(dmem_dataOut),
      .busy(busy), .addr_err(addr_err), .load_count(load_count), .store_count(store_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic acc(input logic en, input logic se, input logic [31:0] a, input logic [63:0] d);
      mem_enable = en;
      store_enable = se;
      dmem_address = a;
      dmem_dataIn = d;
      tick();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_data"}, dmem_dataOut, 64'h0);
      chk({tag, "_busy"}, {63'h0, busy}, 64'h1);
      chk({tag, "_err"}, {63'h0, addr_err}, 64'h0);
      chk({tag, "_lc"}, {48'h0, load_count}, 64'h0);
      chk({tag, "_sc"}, {48'h0, store_count}, 64'h0);
   endtask

   task automatic sweep(input string tag);
      int n = 0;
      while (busy && n < 1000) begin
         mem_enable = 1'b1;
         store_enable = n < 128;
         dmem_address = (n < 128) ? 32'd7 : 32'd300;
         dmem_dataIn = 64'h5555_5555_5555_5555;
         tick();
         n++;
      end
      chk({tag, "_len"}, 64'(n), 64'd256);
      chk({tag, "_lc"}, {48'h0, load_count}, 64'h0);
      chk({tag, "_sc"}, {48'h0, store_count}, 64'h0);
      chk({tag, "_err"}, {63'h0, addr_err}, 64'h0);
      chk({tag, "_data"}, dmem_dataOut, 64'h0);
   endtask

   initial begin
      #3;
      chk_reset("rst0");
      tick();
      tick();
      #1 rst = 1'b0;
      sweep("sweep0");
      acc(1, 0, 7, 0);
      chk("ld7", dmem_dataOut, 64'h0);
      chk("ld7_lc", {48'h0, load_count}, 64'd1);
      acc(1, 0, 5, 0);
      chk("ld5", dmem_dataOut, 64'h0);
      acc(1, 1, 10, 64'hDEAD_BEEF_CAFE_F00D);
      chk("st10_sc", {48'h0, store_count}, 64'd1);
      chk("st10_hold", dmem_dataOut, 64'h0);
      acc(1, 0, 10, 0);
      chk("ld10", dmem_dataOut, 64'hDEAD_BEEF_CAFE_F00D);
      chk("ld10_lc", {48'h0, load_count}, 64'd3);
      acc(0, 1, 3, 64'h1234);
      chk("idle_hold", dmem_dataOut, 64'hDEAD_BEEF_CAFE_F00D);
      chk("idle_sc", {48'h0, store_count}, 64'd1);
      acc(1, 0, 3, 0);
      chk("ld3", dmem_dataOut, 64'h0);
      chk("ld3_err", {63'h0, addr_err}, 64'h0);
      acc(1, 1, 300, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("st300_err", {63'h0, addr_err}, 64'h1);
      chk("st300_sc", {48'h0, store_count}, 64'd2);
      acc(1, 0, 10, 0);
      chk("ld10b", dmem_dataOut, 64'hDEAD_BEEF_CAFE_F00D);
      acc(1, 0, 300, 0);
      chk("ld300", dmem_dataOut, 64'h0);
      chk("ld300_lc", {48'h0, load_count}, 64'd6);
      acc(1, 0, 10, 0);
      acc(1, 0, 44, 0);
      chk("ld44_alias", dmem_dataOut, 64'h0);
      acc(1, 1, 20, 64'h0123_4567_89AB_CDEF);
      acc(1, 0, 20, 0);
      chk("ld20", dmem_dataOut, 64'h0123_4567_89AB_CDEF);
      chk("ld20_err", {63'h0, addr_err}, 64'h1);
      chk("ld20_lc", {48'h0, load_count}, 64'd9);
      chk("ld20_sc", {48'h0, store_count}, 64'd3);
      acc(0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk_reset("rst_ready");
      #2 rst = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      chk("mid_busy", {63'h0, busy}, 64'h1);
      rst = 1'b1;
      #1;
      chk_reset("rst_mid");
      #2 rst = 1'b0;
      sweep("sweep1");
      acc(1, 0, 20, 0);
      chk("ld20_cleared", dmem_dataOut, 64'h0);
      chk("ld20_cleared_lc", {48'h0, load_count}, 64'd1);
      for (int i = 0; i < 65534; i++) acc(1, 0, 0, 0);
      chk("lc_max", {48'h0, load_count}, 64'hFFFF);
      acc(1, 0, 0, 0);
      chk("lc_wrap", {48'h0, load_count}, 64'h0);
      acc(0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
      $finish;
   end
endmodule
